// File: rtl/adder_subtractor.sv
// Registered two's-complement ripple-carry adder/subtractor with signed-overflow flag.
// Optional saturation of the result on overflow is enabled by defining ADD_SUB_SAT_EN.
module adder_subtractor #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             v,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_carry;
    logic             w_overflow;
    logic [WIDTH-1:0] w_result;

    logic [WIDTH-1:0] r_s;
    logic             r_v;
    logic             r_cout;
    logic             r_out_valid;

    // cin doubles as the mode bit: it inverts B and supplies the +1 for subtract
    always_comb begin
        w_bx       = '0;
        w_sum      = '0;
        w_carry    = '0;
        w_carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            w_bx[i]      = b[i] ^ cin;
            w_sum[i]     = a[i] ^ w_bx[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & w_bx[i]) | (a[i] & w_carry[i]) | (w_bx[i] & w_carry[i]);
        end
    end

    assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

`ifdef ADD_SUB_SAT_EN
    // A wrapped result with its sign bit set means the true value overflowed positive
    always_comb begin
        w_result = w_sum;
        if (w_overflow) begin
            w_result = w_sum[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                      : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign w_result = w_sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_v         <= 1'b0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s    <= w_result;
                r_v    <= w_overflow;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign s         = r_s;
    assign v         = r_v;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed and exhaustive self-checking bench for adder_subtractor (WIDTH=5).
// Saturation expectations follow ADD_SUB_SAT_EN when it is defined.
module tb_adder_subtractor;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             v;
    logic             cout;
    logic             out_valid;

    int assertCount;
    int failCount;

    adder_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .v         (v),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Arithmetic reference: integer sum of a + (b or ~b) + cin, sign rule for overflow
    function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb, input logic rc);
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   total;
        logic [WIDTH-1:0] res;
        logic             ovf;
        bx    = rc ? ~rb : rb;
        total = {1'b0, ra} + {1'b0, bx} + {{WIDTH{1'b0}}, rc};
        res   = total[WIDTH-1:0];
        ovf   = (ra[WIDTH-1] == bx[WIDTH-1]) && (res[WIDTH-1] != ra[WIDTH-1]);
`ifdef ADD_SUB_SAT_EN
        if (ovf) res = ra[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {ovf, total[WIDTH], res};
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                 input logic tc, input logic tv);
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = tv;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResult(input string tag, input int es, input int ev, input int ec, input int eo);
        checkOutput({tag, ".s"}, 32'(s), 32'(es));
        checkOutput({tag, ".v"}, 32'(v), 32'(ev));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(ec));
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(eo));
    endtask

    initial begin
        logic [WIDTH+1:0] exp;
        logic [9:0]       idx;
        assertCount = 0;
        failCount   = 0;
        rst_n    = 1'b0;
        a        = WIDTH'($urandom);
        b        = WIDTH'($urandom);
        cin      = 1'b1;
        in_valid = 1'b1;

        // Reset held across an edge with valid inputs present
        @(posedge clk);
        #2;
        checkResult("reset_hold", 0, 0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'd1, 5'd2, 1'b0, 1'b1);
        checkResult("add_1_2", 3, 0, 0, 1);

        applyStimulus(5'd7, 5'd9, 1'b0, 1'b1);
`ifdef ADD_SUB_SAT_EN
        checkResult("add_ovf", 15, 1, 0, 1);
`else
        checkResult("add_ovf", 16, 1, 0, 1);
`endif

        // Asynchronous reset mid-cycle clears registered state without a clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResult("reset_async", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(5'd31, 5'd1, 1'b0, 1'b1);
        checkResult("add_wrap", 0, 0, 1, 1);

        applyStimulus(5'd3, 5'd5, 1'b1, 1'b1);
        checkResult("sub_3_5", 30, 0, 0, 1);

        applyStimulus(5'd16, 5'd1, 1'b1, 1'b1);
`ifdef ADD_SUB_SAT_EN
        checkResult("sub_ovf", 16, 1, 1, 1);
`else
        checkResult("sub_ovf", 15, 1, 1, 1);
`endif

        applyStimulus(5'd0, 5'd16, 1'b1, 1'b1);
`ifdef ADD_SUB_SAT_EN
        checkResult("sub_minneg", 15, 1, 0, 1);
`else
        checkResult("sub_minneg", 16, 1, 0, 1);
`endif

        applyStimulus(5'd4, 5'd4, 1'b0, 1'b1);
        checkResult("hold_load", 8, 0, 0, 1);
        applyStimulus(5'd1, 5'd1, 1'b0, 1'b0);
        checkResult("hold_idle", 8, 0, 0, 0);
        applyStimulus(5'd31, 5'd31, 1'b1, 1'b0);
        checkResult("hold_idle2", 8, 0, 0, 0);

        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 1024; k++) begin
                idx = 10'(k);
                applyStimulus(idx[9:5], idx[4:0], 1'(m), 1'b1);
                exp = refModel(idx[9:5], idx[4:0], 1'(m));
                checkOutput("sweep.s", 32'(s), 32'(exp[WIDTH-1:0]));
                checkOutput("sweep.cout", 32'(cout), 32'(exp[WIDTH]));
                checkOutput("sweep.v", 32'(v), 32'(exp[WIDTH+1]));
            end
        end
        checkOutput("sweep.out_valid", 32'(out_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
